// File: rtl/video_scan_gen.sv
// Raster scan generator: slot-rate horizontal/vertical counters with registered
// fetch address, blanking, sync, line-count register and vertical-line interrupt.
module video_scan_gen #(
    parameter int H_TOTAL        = 64,
    parameter int H_ACTIVE_START = 13,
    parameter int H_ACTIVE_LEN   = 38,
    parameter int H_SYNC_START   = 54,
    parameter int H_SYNC_LEN     = 4,
    parameter int V_TOTAL        = 260,
    parameter int V_SYNC_START   = 256,
    parameter int V_SYNC_LEN     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        slot_en,
    input  logic        video_count_rd,
    output logic [15:0] scan_addr,
    output logic        scan_valid,
    output logic        blank,
    output logic        hsync,
    output logic        vsync,
    output logic        count_240,
    output logic        irq_vline,
    output logic [7:0]  video_count
);

    localparam logic [5:0] H_LAST   = 6'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [5:0] H_AS     = 6'(H_ACTIVE_START);
    localparam logic [6:0] H_AS_EXT = 7'(H_ACTIVE_START);
    localparam logic [6:0] H_AE_EXT = 7'(H_ACTIVE_START + H_ACTIVE_LEN);
    localparam logic [6:0] H_SS     = 7'(H_SYNC_START);
    localparam logic [6:0] H_SE     = 7'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [9:0] V_SS     = 10'(V_SYNC_START);
    localparam logic [9:0] V_SE     = 10'(V_SYNC_START + V_SYNC_LEN);

    logic [5:0]  h_q, h_d;
    logic [8:0]  v_q, v_d;
    logic        wrap;
    logic        active_d;
    logic [5:0]  h_rel;
    logic [6:0]  h_ext;
    logic [9:0]  v_ext;
    logic [15:0] addr_d;
    logic        hsync_d, vsync_d, c240_d, irq_d;
    logic [7:0]  vc_d;

    logic [15:0] addr_q;
    logic        valid_q, blank_q, hsync_q, vsync_q, c240_q, irq_q;
    logic [7:0]  vc_q;

    // Outputs are decoded from the next counter value so they line up with
    // the counter state reached on the same slot edge.
    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        wrap = 1'b0;
        if (slot_en) begin
            if (h_q == H_LAST) begin
                h_d  = '0;
                wrap = 1'b1;
                v_d  = (v_q == V_LAST) ? '0 : v_q + 9'd1;
            end else begin
                h_d = h_q + 6'd1;
            end
        end
        h_ext    = {1'b0, h_d};
        v_ext    = {1'b0, v_d};
        active_d = (h_ext >= H_AS_EXT) && (h_ext < H_AE_EXT) && !v_d[8];
        h_rel    = h_d - H_AS;
        addr_d   = active_d ? {h_rel, 2'b00, v_d[7:0]} : '0;
        hsync_d  = (h_ext >= H_SS) && (h_ext < H_SE);
        vsync_d  = (v_ext >= V_SS) && (v_ext < V_SE);
        c240_d   = !v_d[8] && (v_d[7:4] == 4'hF);
        irq_d    = wrap && !v_d[8] && (v_d[5:0] == 6'd0);
        vc_d     = v_d[8] ? 8'hFC : {v_d[7:2], 2'b00};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q     <= '0;
            v_q     <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            blank_q <= 1'b1;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            c240_q  <= 1'b0;
            irq_q   <= 1'b0;
            vc_q    <= '0;
        end else begin
            irq_q <= slot_en && irq_d;
            if (slot_en) begin
                h_q     <= h_d;
                v_q     <= v_d;
                addr_q  <= addr_d;
                valid_q <= active_d;
                blank_q <= !active_d;
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
                c240_q  <= c240_d;
                if (!video_count_rd)
                    vc_q <= vc_d;
            end
        end
    end

    assign scan_addr   = addr_q;
    assign scan_valid  = valid_q;
    assign blank       = blank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign count_240   = c240_q;
    assign irq_vline   = irq_q;
    assign video_count = vc_q;

endmodule

// File: doc/video_scan_gen.md
VIDEO_SCAN_GEN -- requirements
Module: video_scan_gen

Interface
REQ-001 Parameter H_TOTAL, default 64, slots per line.
REQ-002 Parameter H_ACTIVE_START, default 13, first active slot of a line.
REQ-003 Parameter H_ACTIVE_LEN, default 38, active slots per line (4 screen columns each).
REQ-004 Parameter H_SYNC_START, default 54; H_SYNC_LEN, default 4, hsync slot window.
REQ-005 Parameter V_TOTAL, default 260, lines per frame; lines 0-255 active.
REQ-006 Parameter V_SYNC_START, default 256; V_SYNC_LEN, default 2, vsync line window.
REQ-007 clk  input  1  single system clock, all logic on rising edge.
REQ-008 reset_n  input  1  reset, asynchronous, active-low.
REQ-009 slot_en  input  1  one-clk strobe per video memory slot (E-clock rate).
REQ-010 video_count_rd  input  1  CPU read of the video count register in progress (CBxx, addr[0]=0).
REQ-011 scan_addr  output  16  screen-space fetch address {column[7:0], row[7:0]}.
REQ-012 scan_valid  output  1  scan_addr is an active-region fetch this slot.
REQ-013 blank  output  1  display blanking.
REQ-014 hsync, vsync  output  1 each  sync, active-high.
REQ-015 count_240  output  1  line count in 240..255.
REQ-016 irq_vline  output  1  one-clk interrupt pulse.
REQ-017 video_count  output  8  CPU-readable line count.

Function
REQ-018 h_count (6 bits) and v_count (9 bits) SHALL advance only on clk edges with slot_en=1; otherwise all state holds.
REQ-019 h_count SHALL count 0..H_TOTAL-1, then wrap to 0 and increment v_count; v_count SHALL wrap from V_TOTAL-1 to 0.
REQ-020 All outputs SHALL be registered and reflect the counter value reached on the same slot_en edge (one-clk latency from slot_en).
REQ-021 Active SHALL mean H_ACTIVE_START <= h_count < H_ACTIVE_START+H_ACTIVE_LEN and v_count < 256.
REQ-022 scan_valid SHALL equal active; blank SHALL equal !active.
REQ-023 scan_addr SHALL be {h_rel[5:0], 2'b00, v_count[7:0]} with h_rel = h_count - H_ACTIVE_START when active, 16'h0000 otherwise.
REQ-024 hsync SHALL be high for h_count in [H_SYNC_START, H_SYNC_START+H_SYNC_LEN); vsync for v_count in [V_SYNC_START, V_SYNC_START+V_SYNC_LEN), all slots of those lines.
REQ-025 count_240 SHALL be high for 240 <= v_count <= 255.
REQ-026 irq_vline SHALL pulse high exactly one clk when a line wrap lands on v_count < 256 with v_count[5:0]=0 (lines 0, 64, 128, 192).
REQ-027 video_count SHALL load {v_count[7:2], 2'b00} on each slot_en, or 8'hFC when v_count >= 256.
REQ-028 While video_count_rd=1, video_count SHALL hold; updating resumes on the first slot_en after deassertion.
REQ-029 Parameter combinations with windows exceeding the totals are illegal; behaviour is unspecified.

Reset
REQ-030 reset_n=0 SHALL immediately, without a clock edge, clear h_count, v_count, scan_addr, scan_valid, hsync, vsync, count_240, irq_vline, and video_count to 0, and set blank=1.
REQ-031 Reset mid-frame SHALL abandon the frame; counting restarts at (0,0) on the first slot_en after release.

Verification
REQ-032 Reset, then slot_en every 4 clk for 64 slots -> scan_valid at h 13..50, scan_addr 16'h0000 to 16'h9400, v_count=1 after the 64th strobe.
REQ-033 Run 16640 slots -> vsync high for 128 slots (lines 256-257), count_240 high for 1024 slots, 4 irq_vline pulses; state returns to (0,0).
REQ-034 Hold video_count_rd from line 3 to line 9 -> video_count stays 8'h00, then reads 8'h08 on the next slot_en.
REQ-035 slot_en held low for 1000 clk mid-line -> no output changes.
REQ-036 Assert reset_n low asynchronously at line 100, h 20 -> all outputs at reset values before the next clk edge; blank=1.
